// File: rtl/voice_pkg.sv
// Shared sizing for the voice allocator and a helper to pull one voice's
// field out of the flattened per-voice output buses.
package voice_pkg;

    localparam int NUM_KEYS   = 10;
    localparam int NUM_VOICES = 4;
    localparam int KEY_W      = 4;
    localparam int PITCH_W    = 5;
    localparam int RANK_W     = $clog2(NUM_VOICES);

    // Field idx of width w from a flattened bus (fields packed LSB-first).
    function automatic logic [31:0] voice_field(input logic [31:0] flat,
                                                input int          idx,
                                                input int          w);
        logic [31:0] mask;
        mask = (32'd1 << w) - 32'd1;
        return (flat >> (idx * w)) & mask;
    endfunction

endpackage

// File: rtl/voice_lru.sv
// Age ranks for the voice bank: rank 0 is the most recently allocated voice,
// rank NUM_VOICES-1 is the one to evict when every voice is busy.
module voice_lru
    import voice_pkg::*;
#(
    parameter int NUM_VOICES = voice_pkg::NUM_VOICES,
    parameter int RANK_W     = $clog2(NUM_VOICES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alloc,
    input  logic [RANK_W-1:0] alloc_voice,
    output logic [RANK_W-1:0] oldest
);

    logic [RANK_W-1:0] rank [NUM_VOICES];
    logic [RANK_W-1:0] old_rank;

    always_comb begin
        old_rank = '0;
        oldest   = '0;
        for (int v = 0; v < NUM_VOICES; v++) begin
            if (RANK_W'(v) == alloc_voice)
                old_rank = rank[v];
            if (rank[v] == RANK_W'(NUM_VOICES - 1))
                oldest = RANK_W'(v);
        end
    end

    // Moving a voice to the front only ages the voices that were newer than it,
    // so the ranks stay a permutation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++)
                rank[v] <= RANK_W'(v);
        end else if (alloc) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (RANK_W'(v) == alloc_voice)
                    rank[v] <= '0;
                else if (rank[v] < old_rank)
                    rank[v] <= rank[v] + 1'b1;
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: scans one key per cycle, assigns presses to free
// voices (stealing the oldest when full) and frees voices on release.
module voice_allocator
    import voice_pkg::*;
#(
    parameter int NUM_KEYS   = voice_pkg::NUM_KEYS,
    parameter int NUM_VOICES = voice_pkg::NUM_VOICES,
    parameter int KEY_W      = voice_pkg::KEY_W,
    parameter int PITCH_W    = voice_pkg::PITCH_W
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_KEYS-1:0]           note,
    input  logic [PITCH_W-1:0]            pitchshift,
    input  logic                          clr,
    output logic [NUM_VOICES-1:0]         voice_on,
    output logic [NUM_VOICES*KEY_W-1:0]   voice_key,
    output logic [NUM_VOICES*PITCH_W-1:0] voice_pitch,
    output logic [NUM_VOICES-1:0]         voice_start,
    output logic                          steal
);

    localparam int RANK_W = $clog2(NUM_VOICES);

    logic [KEY_W-1:0]    scan;
    logic [NUM_KEYS-1:0] prev;
    logic [KEY_W-1:0]    key_r   [NUM_VOICES];
    logic [PITCH_W-1:0]  pitch_r [NUM_VOICES];

    logic                  cur_note;
    logic                  prev_note;
    logic                  key_down;
    logic                  key_up;
    logic                  any_free;
    logic [RANK_W-1:0]     free_voice;
    logic [RANK_W-1:0]     oldest;
    logic [RANK_W-1:0]     target;
    logic [NUM_VOICES-1:0] match;
    logic                  alloc;

    always_comb begin
        cur_note  = 1'b0;
        prev_note = 1'b0;
        for (int k = 0; k < NUM_KEYS; k++) begin
            if (scan == KEY_W'(k)) begin
                cur_note  = note[k];
                prev_note = prev[k];
            end
        end
    end

    assign key_down = cur_note & ~prev_note;
    assign key_up   = ~cur_note & prev_note;

    // Descending walk so the lowest-index free voice is the one that sticks.
    always_comb begin
        any_free   = 1'b0;
        free_voice = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (!voice_on[v]) begin
                any_free   = 1'b1;
                free_voice = RANK_W'(v);
            end
        end
    end

    always_comb begin
        match = '0;
        for (int v = 0; v < NUM_VOICES; v++)
            match[v] = voice_on[v] && (key_r[v] == scan);
    end

    assign target = any_free ? free_voice : oldest;
    assign alloc  = key_down & ~clr;

    voice_lru #(
        .NUM_VOICES (NUM_VOICES),
        .RANK_W     (RANK_W)
    ) u_lru (
        .clk         (clk),
        .rst_n       (rst_n),
        .alloc       (alloc),
        .alloc_voice (target),
        .oldest      (oldest)
    );

    // The scan keeps running through clr; clr only silences voices and
    // re-baselines prev so keys still held do not retrigger.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan        <= '0;
            prev        <= '0;
            voice_on    <= '0;
            voice_start <= '0;
            steal       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                key_r[v]   <= '0;
                pitch_r[v] <= '0;
            end
        end else begin
            scan        <= (scan == KEY_W'(NUM_KEYS - 1)) ? '0 : scan + 1'b1;
            voice_start <= '0;
            steal       <= 1'b0;
            if (clr) begin
                voice_on <= '0;
                prev     <= note;
            end else begin
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (scan == KEY_W'(k))
                        prev[k] <= note[k];
                end
                if (key_down) begin
                    for (int v = 0; v < NUM_VOICES; v++) begin
                        if (RANK_W'(v) == target) begin
                            voice_on[v]    <= 1'b1;
                            key_r[v]       <= scan;
                            pitch_r[v]     <= pitchshift;
                            voice_start[v] <= 1'b1;
                        end
                    end
                    steal <= ~any_free;
                end else if (key_up) begin
                    voice_on <= voice_on & ~match;
                end
            end
        end
    end

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_flat
        assign voice_key[v*KEY_W +: KEY_W]       = key_r[v];
        assign voice_pitch[v*PITCH_W +: PITCH_W] = pitch_r[v];
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: per-cycle comparison against a timestamp-based
// allocation model, plus hand-computed literal expectations.
module tb_voice_allocator;
    import voice_pkg::*;

    localparam int NK = NUM_KEYS;
    localparam int NV = NUM_VOICES;
    localparam int KW = KEY_W;
    localparam int PW = PITCH_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NK-1:0]     note = '0;
    logic [PW-1:0]     pitchshift = '0;
    logic              clr = 1'b0;
    logic [NV-1:0]     voice_on;
    logic [NV*KW-1:0]  voice_key;
    logic [NV*PW-1:0]  voice_pitch;
    logic [NV-1:0]     voice_start;
    logic              steal;

    voice_allocator dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .note        (note),
        .pitchshift  (pitchshift),
        .clr         (clr),
        .voice_on    (voice_on),
        .voice_key   (voice_key),
        .voice_pitch (voice_pitch),
        .voice_start (voice_start),
        .steal       (steal)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int steal_seen = 0;
    int start_seen = 0;

    // Model: voice age is the allocation timestamp, oldest = smallest stamp.
    bit m_on    [NV];
    int m_key   [NV];
    int m_pitch [NV];
    int m_stamp [NV];
    bit m_start [NV];
    bit m_steal;
    int m_time;
    int m_scan;
    bit m_prev  [NK];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_on[i] = 0; m_key[i] = 0; m_pitch[i] = 0; m_start[i] = 0;
            m_stamp[i] = -i;
        end
        for (int j = 0; j < NK; j++) m_prev[j] = 0;
        m_steal = 0;
        m_time  = 0;
        m_scan  = 0;
    endtask

    task automatic model_step();
        int k;
        int v;
        bit cur;
        k = m_scan;
        for (int i = 0; i < NV; i++) m_start[i] = 0;
        m_steal = 0;
        if (clr) begin
            for (int i = 0; i < NV; i++) m_on[i] = 0;
            for (int j = 0; j < NK; j++) m_prev[j] = note[j];
        end else begin
            cur = note[k];
            if (cur && !m_prev[k]) begin
                v = -1;
                for (int i = NV - 1; i >= 0; i--) if (!m_on[i]) v = i;
                if (v < 0) begin
                    v = 0;
                    for (int i = 1; i < NV; i++) if (m_stamp[i] < m_stamp[v]) v = i;
                    m_steal = 1;
                end
                m_on[v] = 1; m_key[v] = k; m_pitch[v] = int'(pitchshift);
                m_start[v] = 1;
                m_time++;
                m_stamp[v] = m_time;
            end else if (!cur && m_prev[k]) begin
                for (int i = 0; i < NV; i++) if (m_on[i] && m_key[i] == k) m_on[i] = 0;
            end
            m_prev[k] = cur;
        end
        m_scan = (m_scan + 1) % NK;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step();
    end

    always @(negedge clk) begin
        logic [NV-1:0]    e_on;
        logic [NV-1:0]    e_start;
        logic [NV*KW-1:0] e_key;
        logic [NV*PW-1:0] e_pitch;
        for (int v = 0; v < NV; v++) begin
            e_on[v]    = m_on[v];
            e_start[v] = m_start[v];
            e_key[v*KW +: KW]   = KW'(m_key[v]);
            e_pitch[v*PW +: PW] = PW'(m_pitch[v]);
        end
        check("model voice_on",    64'(voice_on),    64'(e_on));
        check("model voice_key",   64'(voice_key),   64'(e_key));
        check("model voice_pitch", 64'(voice_pitch), 64'(e_pitch));
        check("model voice_start", 64'(voice_start), 64'(e_start));
        check("model steal",       64'(steal),       64'(m_steal));
        if (steal) steal_seen++;
        if (|voice_start) start_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_start(input string name, input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            tick(1);
            if (|voice_start) begin
                ok = 1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: no voice_start within %0d cycles", name, budget);
        end
    endtask

    function automatic logic [63:0] kf(input int v);
        return 64'(voice_field(32'(voice_key), v, KW));
    endfunction

    function automatic logic [63:0] pf(input int v);
        return 64'(voice_field(32'(voice_pitch), v, PW));
    endfunction

    initial begin
        // Reset held for three cycles
        tick(3);
        check("reset voice_on",    64'(voice_on),    64'h0);
        check("reset voice_key",   64'(voice_key),   64'h0);
        check("reset voice_pitch", 64'(voice_pitch), 64'h0);
        check("reset voice_start", 64'(voice_start), 64'h0);
        check("reset steal",       64'(steal),       64'h0);

        // First evaluation after release is key 0
        rst_n = 1'b1;
        note  = 10'b0000000001;
        tick(1);
        check("first eval start", 64'(voice_start), 64'h1);
        check("first eval key",   kf(0),            64'd0);
        note = '0;
        tick(12);
        check("first release on", 64'(voice_on), 64'h0);

        // Single press/release with pitch capture
        pitchshift = 5'd3;
        note = 10'b0000001000;
        wait_start("single press", 12);
        check("single start", 64'(voice_start), 64'h1);
        check("single key",   kf(0),            64'd3);
        check("single pitch", pf(0),            64'd3);
        pitchshift = 5'd9;
        tick(1);
        check("single pulse width", 64'(voice_start), 64'h0);
        check("single pitch held",  pf(0),            64'd3);
        note = '0;
        tick(12);
        check("single release on",  64'(voice_on), 64'h0);
        check("single release key", kf(0),         64'd3);

        // Fill all voices one key at a time, then steal with key 7
        for (int k = 0; k < 4; k++) begin
            note[k] = 1'b1;
            tick(12);
        end
        check("fill on", 64'(voice_on), 64'hF);
        for (int v = 0; v < NV; v++) check("fill key", kf(v), 64'(v));
        note[7] = 1'b1;
        wait_start("steal press", 12);
        check("steal pulse", 64'(steal),       64'h1);
        check("steal start", 64'(voice_start), 64'h1);
        check("steal key",   kf(0),            64'd7);
        note[0] = 1'b0;
        tick(12);
        check("stolen release on", 64'(voice_on), 64'hF);

        // Simultaneous press of all keys right after reset
        note = '0;
        tick(12);
        rst_n = 1'b0;
        tick(1);
        steal_seen = 0;
        rst_n = 1'b1;
        note  = 10'h3FF;
        tick(12);
        check("burst key v0", kf(0), 64'd8);
        check("burst key v1", kf(1), 64'd9);
        check("burst key v2", kf(2), 64'd6);
        check("burst key v3", kf(3), 64'd7);
        check("burst steals", 64'(steal_seen), 64'd6);
        check("burst on",     64'(voice_on),   64'hF);

        // clr while keys 2 and 5 are held
        note = '0;
        tick(12);
        check("clr pre off", 64'(voice_on), 64'h0);
        note = 10'h024;
        tick(12);
        check("clr pre on", 64'(voice_on), 64'h3);
        clr = 1'b1;
        tick(1);
        clr = 1'b0;
        check("clr voice_on", 64'(voice_on),    64'h0);
        check("clr no start", 64'(voice_start), 64'h0);
        start_seen = 0;
        tick(12);
        check("clr no retrigger", 64'(start_seen), 64'd0);
        check("clr stays off",    64'(voice_on),   64'h0);
        note = 10'h020;
        tick(12);
        note = 10'h024;
        wait_start("clr repress", 12);
        check("repress start", 64'(voice_start), 64'h1);
        check("repress key",   kf(0),            64'd2);

        // Reset asserted during an allocation cycle
        note = '0;
        tick(12);
        for (int i = 0; i < 12; i++) begin
            if (m_scan == 4) break;
            tick(1);
        end
        check("align scan", 64'(m_scan), 64'd4);
        note = 10'b0000010000;
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst voice_on",    64'(voice_on),    64'h0);
        check("async rst voice_key",   64'(voice_key),   64'h0);
        check("async rst voice_pitch", 64'(voice_pitch), 64'h0);
        tick(1);
        check("rst alloc no start", 64'(voice_start), 64'h0);
        check("rst alloc no steal", 64'(steal),       64'h0);
        rst_n = 1'b1;
        tick(12);
        check("post rst key4 on", 64'(voice_on), 64'h1);
        check("post rst key4",    kf(0),         64'd4);

        tick(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
